// File: rtl/cordic_arb_pkg.sv
// Shared types and defaults for the CORDIC share arbiter: FSM state encoding,
// default widths and the requester-id width helper.
package cordic_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam int DEF_NUM_REQ     = 4;
    localparam int DEF_ANGLE_W     = 24;
    localparam int DEF_DATA_W      = 24;
    localparam int DEF_TIMEOUT_CYC = 64;

    // A single requester still needs a 1-bit id field.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cordic_share_arbiter_if.sv
// Requester/response and CORDIC-core bus of the share arbiter.
// slave = arbiter view, master = requesters plus core view.
interface cordic_share_arbiter_if
    import cordic_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ANGLE_W = DEF_ANGLE_W,
    parameter int DATA_W  = DEF_DATA_W
);
    localparam int ID_W = id_width(NUM_REQ);

    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ*ANGLE_W-1:0] req_angle;
    logic [NUM_REQ-1:0]         req_ready;

    logic                       resp_valid;
    logic [ID_W-1:0]            resp_id;
    logic [DATA_W-1:0]          resp_sin;
    logic [DATA_W-1:0]          resp_cos;
    logic                       resp_err;

    logic                       cordic_start;
    logic [ANGLE_W-1:0]         cordic_angle;
    logic                       cordic_done;
    logic [DATA_W-1:0]          cordic_sin;
    logic [DATA_W-1:0]          cordic_cos;

    modport slave (
        input  req_valid, req_angle,
        output req_ready,
        output resp_valid, resp_id, resp_sin, resp_cos, resp_err,
        output cordic_start, cordic_angle,
        input  cordic_done, cordic_sin, cordic_cos
    );

    modport master (
        output req_valid, req_angle,
        input  req_ready,
        input  resp_valid, resp_id, resp_sin, resp_cos, resp_err,
        input  cordic_start, cordic_angle,
        output cordic_done, cordic_sin, cordic_cos
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first active request strictly after
// last_grant_i, wrapping, returned both one-hot and encoded.
module rr_arbiter
    import cordic_arb_pkg::*;
#(
    parameter  int NUM_REQ = DEF_NUM_REQ,
    localparam int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    last_grant_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    grant_idx_o,
    output logic               grant_vld_o
);

    logic [ID_W-1:0] cand;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        grant_vld_o = 1'b0;
        cand        = '0;
        // k = NUM_REQ lands back on last_grant, so it is considered last.
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((int'(last_grant_i) + k) % NUM_REQ);
            if (!grant_vld_o && req_i[cand]) begin
                grant_vld_o   = 1'b1;
                grant_idx_o   = cand;
                grant_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cordic_share_arbiter.sv
// Shares one cordic_sincos core between NUM_REQ requesters, one transaction
// in flight. Define CORDIC_ARB_TIMEOUT_EN to abort a WAIT after TIMEOUT_CYC.
module cordic_share_arbiter
    import cordic_arb_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int ANGLE_W     = DEF_ANGLE_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input logic                   system_clock,
    input logic                   rst,
    cordic_share_arbiter_if.slave bus
);

    localparam int ID_W = id_width(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 2) begin : g_param_check
        $error("cordic_share_arbiter: unsupported NUM_REQ or TIMEOUT_CYC");
    end

    arb_state_t         state_q, state_d;
    logic [ANGLE_W-1:0] angle_q, angle_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [ID_W-1:0]    last_grant_q, last_grant_d;
    logic [ID_W-1:0]    resp_id_q, resp_id_d;
    logic [DATA_W-1:0]  resp_sin_q, resp_sin_d;
    logic [DATA_W-1:0]  resp_cos_q, resp_cos_d;
    logic               resp_err_q, resp_err_d;

    logic [NUM_REQ-1:0] grant_oh;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_vld;
    logic               timeout;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req_i        (bus.req_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (grant_oh),
        .grant_idx_o  (grant_idx),
        .grant_vld_o  (grant_vld)
    );

`ifdef CORDIC_ARB_TIMEOUT_EN
    localparam int              CNT_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    // Cleared during ISSUE so the first WAIT cycle sees 0.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_q == ISSUE) begin
            wait_cnt_d = '0;
        end else if (state_q == WAIT) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge system_clock) begin
        if (rst) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign timeout = (wait_cnt_q == CNT_LAST);
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        angle_d      = angle_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        resp_id_d    = resp_id_q;
        resp_sin_d   = resp_sin_q;
        resp_cos_d   = resp_cos_q;
        resp_err_d   = resp_err_q;

        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (grant_oh[i]) begin
                            angle_d = bus.req_angle[i*ANGLE_W +: ANGLE_W];
                        end
                    end
                    id_d         = grant_idx;
                    last_grant_d = grant_idx;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                // A done on the final counted cycle still wins over the abort.
                if (bus.cordic_done) begin
                    resp_sin_d = bus.cordic_sin;
                    resp_cos_d = bus.cordic_cos;
                    resp_id_d  = id_q;
                    resp_err_d = 1'b0;
                    state_d    = RESP;
                end else if (timeout) begin
                    resp_sin_d = '0;
                    resp_cos_d = '0;
                    resp_id_d  = id_q;
                    resp_err_d = 1'b1;
                    state_d    = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge system_clock) begin
        if (rst) begin
            state_q      <= IDLE;
            angle_q      <= '0;
            id_q         <= '0;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            resp_id_q    <= '0;
            resp_sin_q   <= '0;
            resp_cos_q   <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            angle_q      <= angle_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
            resp_id_q    <= resp_id_d;
            resp_sin_q   <= resp_sin_d;
            resp_cos_q   <= resp_cos_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign bus.req_ready    = (state_q == IDLE) ? grant_oh : '0;
    assign bus.cordic_start = (state_q == ISSUE);
    assign bus.cordic_angle = (state_q == IDLE) ? '0 : angle_q;
    assign bus.resp_valid   = (state_q == RESP);
    assign bus.resp_id      = resp_id_q;
    assign bus.resp_sin     = resp_sin_q;
    assign bus.resp_cos     = resp_cos_q;
    assign bus.resp_err     = resp_err_q;

endmodule

// File: tb/tb_cordic_share_arbiter.sv
// Directed self-checking bench for cordic_share_arbiter; the bench itself
// plays the four requesters and a CORDIC core with a chosen latency.
module tb_cordic_share_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    int   last_lat = 0;

    logic [23:0] ang_tbl [4] = '{24'h111111, 24'h222222, 24'h333333, 24'hC44444};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cordic_share_arbiter_if #(.NUM_REQ(4), .ANGLE_W(24), .DATA_W(24)) bus ();

    cordic_share_arbiter #(
        .NUM_REQ     (4),
        .ANGLE_W     (24),
        .DATA_W      (24),
        .TIMEOUT_CYC (64)
    ) dut (
        .system_clock (clk),
        .rst          (rst),
        .bus          (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 32'(bus.req_ready), 32'd0);
        check({tag, "_rvalid"}, 32'(bus.resp_valid), 32'd0);
        check({tag, "_rid"}, 32'(bus.resp_id), 32'd0);
        check({tag, "_rsin"}, 32'(bus.resp_sin), 32'd0);
        check({tag, "_rcos"}, 32'(bus.resp_cos), 32'd0);
        check({tag, "_rerr"}, 32'(bus.resp_err), 32'd0);
        check({tag, "_start"}, 32'(bus.cordic_start), 32'd0);
        check({tag, "_cangle"}, 32'(bus.cordic_angle), 32'd0);
    endtask

    // Called at a negedge with requests already presented; returns at the
    // negedge of the cycle after RESP. drop clears req_valid bits once granted.
    task automatic run_txn(input int exp_id, input logic [23:0] ang, input logic [23:0] s,
                           input logic [23:0] c, input int lat, input logic [3:0] drop);
        int n;
        int t0;
        #1;
        n = 0;
        while (bus.req_ready == 4'b0000 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("grant", 32'(bus.req_ready), 32'd1 << exp_id);
        t0 = cyc;
        @(negedge clk);
        bus.req_valid = bus.req_valid & ~drop;
        check("start", 32'(bus.cordic_start), 32'd1);
        check("cordic_angle", 32'(bus.cordic_angle), 32'(ang));
        check("ready_off_issue", 32'(bus.req_ready), 32'd0);
        repeat (lat) begin
            @(negedge clk);
            check("no_early_resp", 32'(bus.resp_valid), 32'd0);
        end
        bus.cordic_done = 1'b1;
        bus.cordic_sin  = s;
        bus.cordic_cos  = c;
        @(negedge clk);
        bus.cordic_done = 1'b0;
        bus.cordic_sin  = 24'h5A5A5A;
        bus.cordic_cos  = 24'hA5A5A5;
        check("resp_valid", 32'(bus.resp_valid), 32'd1);
        check("resp_id", 32'(bus.resp_id), 32'(exp_id));
        check("resp_sin", 32'(bus.resp_sin), 32'(s));
        check("resp_cos", 32'(bus.resp_cos), 32'(c));
        check("resp_err", 32'(bus.resp_err), 32'd0);
        last_lat = cyc - t0;
        @(negedge clk);
        check("resp_one_cycle", 32'(bus.resp_valid), 32'd0);
        check("resp_sin_hold", 32'(bus.resp_sin), 32'(s));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int tw;
        logic [23:0] s_v;
        logic [23:0] c_v;

        bus.req_valid   = 4'b0000;
        bus.req_angle   = '0;
        bus.cordic_done = 1'b0;
        bus.cordic_sin  = '0;
        bus.cordic_cos  = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check_all_zero("rst");
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("post_rst");

        // Round-robin fairness: all four held valid, 0,1,2,3,0,1,2,3
        bus.req_angle = {ang_tbl[3], ang_tbl[2], ang_tbl[1], ang_tbl[0]};
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            s_v = 24'h0A0000 + 24'(k);
            c_v = 24'hF50000 + 24'(k);
            run_txn(k % 4, ang_tbl[k % 4], s_v, c_v, 2, (k == 7) ? 4'b1111 : 4'b0000);
        end

        // Single request, 3-cycle core: ready cycle to resp cycle is 5
        bus.req_angle = {24'h0, 24'h0, 24'h0, 24'h200000};
        bus.req_valid = 4'b0001;
        run_txn(0, 24'h200000, 24'h16A09E, 24'h16A09F, 3, 4'b0001);
        check("latency_3cyc", 32'(last_lat), 32'd5);

        // Wrap and skip: last_grant=2, requesters 1 and 3 -> 3 then 1
        bus.req_angle = {24'h300003, 24'h300002, 24'h300001, 24'h300000};
        bus.req_valid = 4'b0100;
        run_txn(2, 24'h300002, 24'h000102, 24'hFFFF02, 1, 4'b0100);
        bus.req_valid = 4'b1010;
        run_txn(3, 24'h300003, 24'h000103, 24'hFFFF03, 1, 4'b1000);
        run_txn(1, 24'h300001, 24'h000101, 24'hFFFF01, 1, 4'b0010);
        check("latency_1cyc", 32'(last_lat), 32'd3);

        // Stray cordic_done in IDLE is ignored
        bus.cordic_done = 1'b1;
        bus.cordic_sin  = 24'h123456;
        bus.cordic_cos  = 24'h654321;
        @(negedge clk);
        bus.cordic_done = 1'b0;
        check("stray_no_resp", 32'(bus.resp_valid), 32'd0);
        @(negedge clk);
        check("stray_no_resp2", 32'(bus.resp_valid), 32'd0);
        check("stray_not_latched", 32'(bus.resp_sin), 32'h000101);
        bus.req_valid = 4'b0010;
        run_txn(1, 24'h300001, 24'h0ABCDE, 24'h0FEDCB, 2, 4'b0010);

        // Reset during WAIT: transaction dropped, requester 0 regains priority
        bus.req_valid = 4'b0001;
        #1;
        check("rstw_grant", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        bus.req_valid = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("rst_wait");
        bus.cordic_done = 1'b1;
        bus.cordic_sin  = 24'h777777;
        @(negedge clk);
        bus.cordic_done = 1'b0;
        n = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.resp_valid !== 1'b0) n++;
        end
        check("rst_wait_no_resp", 32'(n), 32'd0);
        bus.req_valid = 4'b0011;
        run_txn(0, 24'h300000, 24'h000200, 24'hFFFE00, 1, 4'b0001);
        run_txn(1, 24'h300001, 24'h000201, 24'hFFFE01, 1, 4'b0010);

`ifdef CORDIC_ARB_TIMEOUT_EN
        // Core never answers: abort 64 cycles after WAIT entry
        bus.req_valid = 4'b0001;
        #1;
        check("to_grant", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        bus.req_valid = 4'b0000;
        @(negedge clk);
        tw = cyc;
        n = 0;
        while (bus.resp_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("to_resp_valid", 32'(bus.resp_valid), 32'd1);
        check("to_delay", 32'(cyc - tw), 32'd64);
        check("to_err", 32'(bus.resp_err), 32'd1);
        check("to_sin", 32'(bus.resp_sin), 32'd0);
        check("to_cos", 32'(bus.resp_cos), 32'd0);
        check("to_id", 32'(bus.resp_id), 32'd0);
        @(negedge clk);
        bus.cordic_done = 1'b1;
        bus.cordic_sin  = 24'h444444;
        @(negedge clk);
        bus.cordic_done = 1'b0;
        check("to_late_done", 32'(bus.resp_valid), 32'd0);
        bus.req_valid = 4'b0100;
        run_txn(2, 24'h300002, 24'h000302, 24'hFFFD02, 3, 4'b0100);
`else
        tw = 0;
`endif

        check("final_idle_start", 32'(bus.cordic_start) + 32'(tw * 0), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
